seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential restoring divider; the inverse of the team's `seq_multi` shift-add multiplier.
- Takes a 2*dp_width-bit dividend (e.g. a product from `seq_multi`) and a dp_width-bit divisor.
- Produces a dp_width-bit quotient and remainder, one quotient bit per clock.
- Uses the same start/ready handshake as `seq_multi`, so the two can be chained for multiply-then-divide checks.

Parameters:
- dp_width, 5, operand width N; dividend is 2N bits, quotient and remainder are N bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- dividend  input  2*dp_width  numerator; sampled only when a start is accepted.
- divisor  input  dp_width  denominator; sampled only when a start is accepted.
- start  input  1  request a division; accepted only when ready=1.
- quotient  output  dp_width  result quotient (registered).
- remainder  output  dp_width  result remainder (registered).
- ready  output  1  1 = idle, results valid; 0 = division in progress.
- overflow  output  1  last accepted operation overflowed (divisor=0 or quotient does not fit in N bits).

Behaviour:
- Reset: at a clk edge with reset=1, state=IDLE, ready=1, quotient=0, remainder=0, overflow=0, iteration count=0. This overrides start.
- States: IDLE, BUSY.
- IDLE:
  - If start=1 at edge k, operands are captured.
  - Overflow check at capture: divisor==0, or dividend[2N-1:N] >= divisor.
  - Overflow case: stay IDLE, ready stays 1. After edge k: quotient = all ones, remainder = 0, overflow = 1. Zero-latency completion.
  - Normal case: go to BUSY; ready=0 after edge k.
  - Working regs are loaded: R (N+1 bits) = {0, dividend[2N-1:N]}, Q = dividend[N-1:0], count = 0.
  - overflow is cleared to 0 at edge k.
- BUSY, one iteration per edge:
  - Shift {R,Q} left by 1.
  - Compute t = R - {0,divisor} at N+1 bits.
  - If t is non-negative (MSB of t = 0): R = t and Q[0] = 1; otherwise Q[0] = 0.
  - count increments.
- Iteration N (edge k+N): quotient <= final Q, remainder <= final R[N-1:0], ready=1, state returns to IDLE.
- Latency: ready is low for exactly N cycles (edges k+1..k+N). Results are visible after edge k+N.
- quotient/remainder/overflow hold their previous values while BUSY and between operations. They change only at completion or on an overflow capture.
- start while BUSY: ignored; no effect on the operation in flight. Operands may change freely while BUSY.
- Back-to-back: start=1 in the same cycle ready returns high is accepted at the next edge. Maximum throughput is one result per N+1 cycles.
- Reset while BUSY: aborts immediately; all outputs take their reset values at that edge.
- Invariants when no overflow: quotient*divisor + remainder == dividend, and remainder < divisor.

Test Plan:
- Exact division, N=5: reset for 1 cycle; dividend=253 (10'b0011111101), divisor=11, start 1 cycle -> ready low for 5 cycles, then quotient=23, remainder=0, overflow=0.
- Remainder: dividend=254, divisor=11 -> quotient=23, remainder=1. Max legal case: dividend=991, divisor=31 -> quotient=31, remainder=30, after 5 busy cycles.
- Overflow cases, with no ready drop in either:
  - dividend=352, divisor=11 (high half 11 >= 11) -> overflow=1, quotient=31, remainder=0 one edge after start.
  - divisor=0, any dividend -> same response.
  - A following legal start clears overflow.
- Busy-ignore and back-to-back:
  - Hold start=1 with changing operands during BUSY -> result matches only the first captured operands (253/11 -> 23 r0).
  - Keep start high as ready rises -> a second operation starts on the next edge.
- Reset mid-operation: assert reset at the 3rd BUSY edge -> ready=1, quotient=0, remainder=0, overflow=0 after that edge. A new 254/11 then yields 23 r1.
- Chained check:
  - Feed `seq_multi` products of random 5-bit operands a,b (b != 0) into the divider with divisor=b.
  - Flag mismatch if quotient != a or remainder != 0; cover at least 200 random pairs.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock
module seq_divider #(
    parameter int dp_width = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2*dp_width-1:0] dividend,
    input  logic [dp_width-1:0]   divisor,
    input  logic                  start,
    output logic [dp_width-1:0]   quotient,
    output logic [dp_width-1:0]   remainder,
    output logic                  ready,
    output logic                  overflow
);
    localparam int N  = dp_width;
    localparam int CW = $clog2(N + 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t        state_q;
    logic [N:0]    r_q, r_d, sh_r, t;
    logic [N-1:0]  q_q, q_d, d_q, quotient_q, remainder_q;
    logic [CW-1:0] cnt_q;
    logic          ready_q, overflow_q, ovf;
    assign ovf = (divisor == '0) || (dividend[2*N-1:N] >= divisor);
    // Trial subtraction on the shifted partial remainder; a clear MSB means it fits.
    always_comb begin
        sh_r = {r_q[N-1:0], q_q[N-1]};
        t    = sh_r - {1'b0, d_q};
        r_d  = t[N] ? sh_r : t;
        q_d  = {q_q[N-2:0], ~t[N]};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            quotient_q  <= '0;
            remainder_q <= '0;
            overflow_q  <= 1'b0;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
        end else if (state_q == IDLE) begin
            if (start && ovf) begin
                quotient_q  <= '1;
                remainder_q <= '0;
                overflow_q  <= 1'b1;
            end else if (start) begin
                state_q    <= BUSY;
                ready_q    <= 1'b0;
                overflow_q <= 1'b0;
                r_q        <= {1'b0, dividend[2*N-1:N]};
                q_q        <= dividend[N-1:0];
                d_q        <= divisor;
                cnt_q      <= '0;
            end
        end else begin
            r_q   <= r_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
                quotient_q  <= q_d;
                remainder_q <= r_d[N-1:0];
                state_q     <= IDLE;
                ready_q     <= 1'b1;
            end
        end
    end
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ready     = ready_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized self-checking bench for seq_divider against an arithmetic model
module tb_seq_divider;
    localparam int N = 5;
    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [2*N-1:0] dividend = '0;
    logic [N-1:0]   divisor = '0;
    logic           start = 1'b0;
    logic [N-1:0]   quotient, remainder;
    logic           ready, overflow;
    int checks = 0;
    int failures = 0;
    logic [N-1:0] hq = '0, hr = '0;
    logic         ho = 1'b0;

    seq_divider #(.dp_width(N)) dut (
        .clk(clk), .reset(reset), .dividend(dividend), .divisor(divisor),
        .start(start), .quotient(quotient), .remainder(remainder),
        .ready(ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                         output logic [N-1:0] eq, output logic [N-1:0] er, output logic eo);
        int a, b;
        a  = int'(dvd);
        b  = int'(dvs);
        eo = (b == 0) || (a / 32 >= b);
        eq = '1;
        er = '0;
        if (!eo) begin
            eq = N'(a / b);
            er = N'(a % b);
        end
    endtask

    task automatic run_div(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs, input string nm);
        logic [N-1:0] eq, er;
        logic eo;
        int busy;
        model(dvd, dvs, eq, er, eo);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        tick();
        start = 1'b0;
        busy  = 0;
        while (!ready && busy < 20) begin
            checks++;
            if ({quotient, remainder, overflow} !== {hq, hr, 1'b0})
                $display("FAIL %s hold: got q=%0d r=%0d o=%0b want q=%0d r=%0d o=0",
                         nm, quotient, remainder, overflow, hq, hr);
            if ({quotient, remainder, overflow} !== {hq, hr, 1'b0}) failures++;
            tick();
            busy++;
        end
        checks++;
        if (busy != (eo ? 0 : N)) begin
            failures++;
            $display("FAIL %s latency: got %0d busy cycles want %0d", nm, busy, eo ? 0 : N);
        end
        checks++;
        if ({quotient, remainder, overflow} !== {eq, er, eo}) begin
            failures++;
            $display("FAIL %s result %0d/%0d: got q=%0d r=%0d o=%0b want q=%0d r=%0d o=%0b",
                     nm, dvd, dvs, quotient, remainder, overflow, eq, er, eo);
        end
        hq = eq;
        hr = er;
        ho = eo;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b1;
        dividend = 10'd352;
        divisor  = 5'd11;
        tick();
        tick();
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if ({ready, quotient, remainder, overflow} !== {1'b1, 5'd0, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset: got rdy=%0b q=%0d r=%0d o=%0b want rdy=1 q=0 r=0 o=0",
                     ready, quotient, remainder, overflow);
        end
        hq = '0;
        hr = '0;
        ho = 1'b0;
    endtask

    task automatic test_directed();
        run_div(10'd253, 5'd11, "exact");
        run_div(10'd254, 5'd11, "rem");
        run_div(10'd991, 5'd31, "max");
        run_div(10'd0, 5'd1, "zero_dividend");
        run_div(10'd31, 5'd1, "div_by_one");
    endtask

    task automatic test_overflow();
        run_div(10'd352, 5'd11, "ovf_high");
        run_div(10'($urandom_range(0, 1023)), 5'd0, "ovf_div0");
        run_div(10'd991, 5'd30, "ovf_edge");
        run_div(10'd254, 5'd11, "ovf_clear");
    endtask

    task automatic test_back_to_back();
        int busy;
        dividend = 10'd253;
        divisor  = 5'd11;
        start    = 1'b1;
        tick();
        busy = 0;
        while (!ready && busy < 20) begin
            dividend = 10'($urandom_range(0, 1023));
            divisor  = 5'($urandom_range(0, 31));
            tick();
            busy++;
        end
        checks++;
        if (busy != N || {quotient, remainder, overflow} !== {5'd23, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL busy_ignore: got busy=%0d q=%0d r=%0d o=%0b want busy=5 q=23 r=0 o=0",
                     busy, quotient, remainder, overflow);
        end
        dividend = 10'd254;
        divisor  = 5'd11;
        tick();
        start = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: got rdy=%0b want rdy=0", ready);
        end
        busy = 0;
        while (!ready && busy < 20) begin
            tick();
            busy++;
        end
        checks++;
        if (busy != N || {quotient, remainder, overflow} !== {5'd23, 5'd1, 1'b0}) begin
            failures++;
            $display("FAIL b2b_result: got busy=%0d q=%0d r=%0d o=%0b want busy=5 q=23 r=1 o=0",
                     busy, quotient, remainder, overflow);
        end
        hq = 5'd23;
        hr = 5'd1;
        ho = 1'b0;
    endtask

    task automatic test_reset_mid();
        dividend = 10'd253;
        divisor  = 5'd11;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({ready, quotient, remainder, overflow} !== {1'b1, 5'd0, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid: got rdy=%0b q=%0d r=%0d o=%0b want rdy=1 q=0 r=0 o=0",
                     ready, quotient, remainder, overflow);
        end
        hq = '0;
        hr = '0;
        ho = 1'b0;
        run_div(10'd254, 5'd11, "after_reset");
    endtask

    task automatic test_chained();
        logic [N-1:0] a, b;
        for (int i = 0; i < 200; i++) begin
            a = 5'($urandom_range(0, 31));
            b = 5'($urandom_range(1, 31));
            run_div(10'(int'(a) * int'(b)), b, "chain");
            checks++;
            if (quotient !== a || remainder !== 5'd0) begin
                failures++;
                $display("FAIL chain %0d*%0d: got q=%0d r=%0d want q=%0d r=0", a, b, quotient, remainder, a);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++)
            run_div(10'($urandom_range(0, 1023)), 5'($urandom_range(0, 31)), "random");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_chained();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
